// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, NOP encoding, index widths.
package pipeline_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned FC_W      = 3;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and stall/flush controls.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import pipeline_pkg::*;

    logic                 enable;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_mem_read;
    logic                 ex_redirect;
    logic                 cnt_clr;

    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_bubble;
    logic                 flush;
    logic                 busy_flush;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output enable, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_redirect, cnt_clr,
        input  pc_en, if_id_en, id_ex_bubble, flush, busy_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  enable, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_redirect, cnt_clr,
        output pc_en, if_id_en, id_ex_bubble, flush, busy_flush, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall detection and multi-cycle wrong-path flush sequencing for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e       state_q, state_d;
    logic [FC_W-1:0] fc_q, fc_d;

    logic luse;
    logic pc_en_c;
    logic if_id_en_c;
    logic bubble_c;
    logic flush_c;
    logic stall_inc_c;
    logic flush_inc_c;

    // Load in EXE whose destination is read by the instruction in ID; x0 never hazards.
    assign luse = hz.ex_mem_read && (hz.ex_rd != '0) &&
                  ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_RUN;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    // Redirect outranks load-use; the flush sequence ignores both hazard sources.
    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        pc_en_c     = 1'b0;
        if_id_en_c  = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        stall_inc_c = 1'b0;
        flush_inc_c = 1'b0;

        if (hz.enable) begin
            case (state_q)
                ST_RUN: begin
                    if (hz.ex_redirect) begin
                        flush_c     = 1'b1;
                        flush_inc_c = 1'b1;
                        pc_en_c     = 1'b1;
                        if_id_en_c  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            fc_d    = FC_W'(FLUSH_CYCLES - 1);
                        end
                    end else if (luse) begin
                        bubble_c    = 1'b1;
                        stall_inc_c = 1'b1;
                    end else begin
                        pc_en_c    = 1'b1;
                        if_id_en_c = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_c    = 1'b1;
                    pc_en_c    = 1'b1;
                    if_id_en_c = 1'b1;
                    fc_d       = fc_q - FC_W'(1);
                    if (fc_q == FC_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fc_d    = '0;
                end
            endcase
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.if_id_en     = if_id_en_c;
    assign hz.id_ex_bubble = bubble_c;
    assign hz.flush        = flush_c;
    assign hz.busy_flush   = (state_q == ST_FLUSH);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (hz.enable),
        .inc    (stall_inc_c),
        .clr    (hz.cnt_clr),
        .count  (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (hz.enable),
        .inc    (flush_inc_c),
        .clr    (hz.cnt_clr),
        .count  (hz.flush_cnt)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RV64 pipeline (IF, ID, EXE, MEM, WB).
- Detects load-use hazards between ID and EXE and produces one-cycle stalls: PC and IF/ID hold, ID/EXE gets a bubble.
- Sequences the multi-cycle squash of wrong-path instructions after a taken branch or jump resolved in EXE. The PC redirect passes through the EXE->IF pipeline register, so younger instructions must be flushed for several cycles.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- FLUSH_CYCLES, 3, consecutive cycles flush is asserted after a redirect (legal range 1..7).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- enable  input  1  global run enable; 0 freezes the controller
- id_rs1  input  5  rs1 field of instruction in ID
- id_rs2  input  5  rs2 field of instruction in ID
- id_uses_rs2  input  1  ID instruction reads rs2 (R-type, store, branch)
- ex_rd  input  5  rd field of instruction in EXE
- ex_mem_read  input  1  EXE instruction is a load
- ex_redirect  input  1  EXE resolved a taken branch or a jump this cycle
- cnt_clr  input  1  synchronous clear of both counters
- pc_en  output  1  PC update enable
- if_id_en  output  1  IF/ID register enable
- id_ex_bubble  output  1  force ID/EXE control signals to zero (NOP)
- flush  output  1  squash IF/ID and ID/EXE contents (write NOP)
- busy_flush  output  1  FSM is in FLUSH state
- stall_cnt  output  CNT_W  number of load-use stall cycles
- flush_cnt  output  CNT_W  number of redirect events

Behaviour:
- Reset (arst_n=0, async):
  - state=RUN, flush counter fc=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs evaluate with enable gating, so pc_en=0 and if_id_en=0 while enable=0.
- Hazard term: luse = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- FSM states: RUN, FLUSH; fc is a 3-bit down-counter.
- RUN, enable=1:
  - ex_redirect=1: flush=1 this cycle (combinational), flush_cnt++. If FLUSH_CYCLES>1, go to FLUSH with fc=FLUSH_CYCLES-1; otherwise stay in RUN.
  - else luse=1: pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt++. Stay in RUN; the stall naturally lasts 1 cycle because the load advances to MEM.
  - else: pc_en=1, if_id_en=1, all other control outputs 0.
- FLUSH, enable=1:
  - flush=1, pc_en=1, if_id_en=1, luse ignored (the ID instruction is wrong-path), fc--.
  - When fc reaches 1 and is consumed, go to RUN.
  - ex_redirect=1 in FLUSH: ignored; the EXE instruction is already squashed.
- enable=0: state, fc and counters hold; pc_en=0, if_id_en=0, flush=0, id_ex_bubble=0.
- Priority: redirect > load-use stall > normal.
- Simultaneous redirect and luse in RUN: redirect wins, no stall, stall_cnt unchanged.
- Counters:
  - Saturate at all-ones, no wrap.
  - cnt_clr has priority over increment in the same cycle.
- busy_flush = (state==FLUSH).
- Total flush length per redirect is exactly FLUSH_CYCLES enabled cycles.
- Async reset mid-FLUSH: immediate return to RUN with flush=0.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding (RUN=1'b0, FLUSH=1'b1)
  - NOP instruction constant 32'h00000013
  - register-index width 5
- One sub-module, sat_counter (parameter W; inputs inc, clr, en; output count), instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt=1.
- x0 and rs2 rules: ex_rd=0 with id_rs1=0 -> no stall. ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall; with id_uses_rs2=1 -> stall.
- Redirect: single-cycle ex_redirect pulse in RUN, FLUSH_CYCLES=3 -> flush=1 for exactly 3 cycles and busy_flush=1 for the last 2; flush_cnt=1.
- Redirect during FLUSH, and luse during FLUSH:
  - Redirect pulse in FLUSH -> no extension, flush_cnt unchanged.
  - luse=1 in FLUSH -> no stall.
- Simultaneous redirect and luse in RUN -> flush=1, id_ex_bubble=0, stall_cnt unchanged.
- Enable, reset and saturation:
  - enable dropped mid-FLUSH for 4 cycles -> fc frozen, flush=0; flush resumes for the remaining cycles.
  - arst_n pulse mid-FLUSH -> RUN, counters 0.
  - CNT_W=4 with 20 stalls -> stall_cnt=15.
